// File: rtl/tx_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tx_buf_ctrl
// Moves bytes from a host write port into an external single-port 4-entry
// buffer, then presents them one at a time to a transmitter.
// The buffer is operated as a FIFO with 2-bit write and read pointers that
// wrap 3->0. Both pointers share the one buffer port, so a write and a read
// can never happen in the same cycle.
//
// Optional feature: define TX_BUF_CTRL_PARITY_EN to add the txParity output,
// which is the even parity of txData and is registered alongside it.
//
// Ports
//   tClk      : clock, all state updates on the rising edge
//   tRst      : asynchronous active-low reset
//   hPush     : host write request, data on hData
//   hData     : host write data
//   hAck      : push accepted this cycle (combinational)
//   hFull     : 4 entries held
//   bEmpty    : no entries held
//   tCount    : number of entries held, 0..4
//   bWR/bRD   : buffer write / read strobes (never both high)
//   bAddr     : buffer entry address
//   bDataOut  : write data to buffer (follows hData)
//   bDataIn   : buffer read data, valid the cycle after bRD
//   txValid   : txData holds a byte for the transmitter
//   txData    : byte to the transmitter (registered)
//   txReady   : transmitter takes the byte when txValid && txReady
//   txParity  : even parity of txData (only with TX_BUF_CTRL_PARITY_EN)
// -----------------------------------------------------------------------------
module tx_buf_ctrl #(
  parameter int BITWIDTH = 8
) (
  input  logic                tClk,
  input  logic                tRst,
  input  logic                hPush,
  input  logic [BITWIDTH-1:0] hData,
  output logic                hAck,
  output logic                hFull,
  output logic                bEmpty,
  output logic [2:0]          tCount,
  output logic                bWR,
  output logic                bRD,
  output logic [1:0]          bAddr,
  output logic [BITWIDTH-1:0] bDataOut,
  input  logic [BITWIDTH-1:0] bDataIn,
  output logic                txValid,
  output logic [BITWIDTH-1:0] txData,
  input  logic                txReady
`ifdef TX_BUF_CTRL_PARITY_EN
  ,
  output logic                txParity
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, PRESENT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          wptr_q, wptr_d;
  logic [1:0]          rptr_q, rptr_d;
  logic [2:0]          count_q, count_d;
  logic                rr_q, rr_d;
  logic                tx_valid_q, tx_valid_d;
  logic [BITWIDTH-1:0] tx_data_q, tx_data_d;

  logic wr_req;
  logic rd_req;
  logic wr_go;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rr_d       = rr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    wr_go      = 1'b0;

    wr_req = hPush && (count_q != 3'd4);
    rd_req = (state_q == IDLE) && (count_q != 3'd0);

    case (state_q)
      IDLE: begin
        // rr=1 favours the read side when both sides want the buffer port.
        if (rd_req && (!wr_req || rr_q)) begin
          state_d = READ;
        end else begin
          wr_go = wr_req;
        end
        // The winner hands priority to the other side; with only one
        // requester the priority bit is left alone.
        if (rd_req && wr_req) begin
          rr_d = ~rr_q;
        end
      end
      READ: begin
        state_d = CAPT;
        rptr_d  = rptr_q + 2'd1;
        count_d = count_q - 3'd1;
      end
      CAPT: begin
        wr_go      = wr_req;
        tx_data_d  = bDataIn;
        tx_valid_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        wr_go = wr_req;
        if (txReady) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write never coincides with the READ-state decrement.
    if (wr_go) begin
      wptr_d  = wptr_q + 2'd1;
      count_d = count_q + 3'd1;
    end
  end

  // Buffer port strobes. Gated by tRst so they drop the moment reset is
  // asserted, even while hPush is still high.
  always_comb begin
    hAck  = 1'b0;
    bWR   = 1'b0;
    bRD   = 1'b0;
    bAddr = 2'd0;
    if (tRst) begin
      hAck = wr_go;
      bWR  = wr_go;
      bRD  = (state_q == READ);
      if (state_q == READ) begin
        bAddr = rptr_q;
      end else if (wr_go) begin
        bAddr = wptr_q;
      end
    end
  end

  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      state_q    <= IDLE;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      count_q    <= 3'd0;
      rr_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef TX_BUF_CTRL_PARITY_EN
  logic tx_parity_q, tx_parity_d;

  always_comb begin
    tx_parity_d = ^tx_data_d;
  end

  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      tx_parity_q <= 1'b0;
    end else begin
      tx_parity_q <= tx_parity_d;
    end
  end

  assign txParity = tx_parity_q;
`endif

  assign bDataOut = hData;
  assign tCount   = count_q;
  assign hFull    = (count_q == 3'd4);
  assign bEmpty   = (count_q == 3'd0);
  assign txValid  = tx_valid_q;
  assign txData   = tx_data_q;

endmodule

// File: tb/tb_tx_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_buf_ctrl
// Self-checking bench for tx_buf_ctrl. A behavioural single-port buffer with
// registered read is attached to the buffer port. Accepted host bytes go into
// a scoreboard queue and are compared in order against every transmitter
// handshake. A negedge monitor also tracks expected buffer addresses, the
// bWR/bRD exclusion and the bRD-to-txValid latency. A vector table covers the
// fill-to-full sequence; hand-written sequences cover arbitration, holding
// under back-pressure and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_tx_buf_ctrl;

  localparam int W = 8;

  logic         tClk = 1'b0;
  logic         tRst = 1'b0;
  logic         hPush = 1'b0;
  logic [W-1:0] hData = '0;
  logic         hAck, hFull, bEmpty, bWR, bRD, txValid;
  logic [2:0]   tCount;
  logic [1:0]   bAddr;
  logic [W-1:0] bDataOut, txData;
  logic [W-1:0] bDataIn = '0;
  logic         txReady = 1'b0;
`ifdef TX_BUF_CTRL_PARITY_EN
  logic         txParity;
`endif

  tx_buf_ctrl #(.BITWIDTH(W)) dut (
    .tClk     (tClk),
    .tRst     (tRst),
    .hPush    (hPush),
    .hData    (hData),
    .hAck     (hAck),
    .hFull    (hFull),
    .bEmpty   (bEmpty),
    .tCount   (tCount),
    .bWR      (bWR),
    .bRD      (bRD),
    .bAddr    (bAddr),
    .bDataOut (bDataOut),
    .bDataIn  (bDataIn),
    .txValid  (txValid),
    .txData   (txData),
    .txReady  (txReady)
`ifdef TX_BUF_CTRL_PARITY_EN
    ,
    .txParity (txParity)
`endif
  );

  always #5 tClk = ~tClk;

  // Buffer model: write on bWR, registered read on bRD.
  logic [W-1:0] mem [4];
  always @(posedge tClk) begin
    if (bWR) mem[bAddr] <= bDataOut;
    if (bRD) bDataIn <= mem[bAddr];
  end

  int cyc = 0;
  always @(posedge tClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           rd_cyc_q[$];
  logic [1:0]   m_wptr = 2'd0;
  logic [1:0]   m_rptr = 2'd0;
  logic         valid_prev = 1'b0;

  initial begin
    forever begin
      @(negedge tClk);
      if (!tRst) begin
        exp_q.delete();
        rd_cyc_q.delete();
        m_wptr     = 2'd0;
        m_rptr     = 2'd0;
        valid_prev = 1'b0;
      end else begin
        chk("wr_rd_exclusive", {31'd0, bWR & bRD}, 32'd0);
        if (bWR) begin
          chk("wr_addr", {30'd0, bAddr}, {30'd0, m_wptr});
          chk("wr_data", {24'd0, bDataOut}, {24'd0, hData});
          m_wptr = m_wptr + 2'd1;
        end
        if (hAck) exp_q.push_back(hData);
        if (bRD) begin
          chk("rd_addr", {30'd0, bAddr}, {30'd0, m_rptr});
          m_rptr = m_rptr + 2'd1;
          rd_cyc_q.push_back(cyc);
        end
        if (txValid && !valid_prev) begin
          chk("latency_src", rd_cyc_q.size(), 32'd1);
          if (rd_cyc_q.size() > 0) chk("latency", cyc - rd_cyc_q.pop_front(), 32'd2);
        end
        if (txValid && txReady) begin
          chk("tx_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            $display("tx byte %02h expected %02h", txData, e);
            chk("tx_data", {24'd0, txData}, {24'd0, e});
          end
        end
`ifdef TX_BUF_CTRL_PARITY_EN
        if (txValid) chk("parity", {31'd0, txParity}, {31'd0, ^txData});
`endif
        valid_prev = txValid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Called at posedge+1: drive one cycle, check at negedge, return at posedge+1.
  task automatic drive_chk(input string nm, input logic p, input logic [W-1:0] d,
                           input logic r, input logic e_ack, input logic e_rd);
    hPush = p; hData = d; txReady = r;
    @(negedge tClk);
    $display("%s push=%0b data=%02h ack=%0b rd=%0b", nm, p, d, hAck, bRD);
    chk({nm, "_ack"}, {31'd0, hAck}, {31'd0, e_ack});
    chk({nm, "_rd"},  {31'd0, bRD},  {31'd0, e_rd});
    @(posedge tClk); #1;
  endtask

  task automatic drain(input string nm);
    int k;
    hPush = 1'b0; txReady = 1'b1; k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      @(posedge tClk); #1; k++;
    end
    chk({nm, "_drained"}, exp_q.size(), 32'd0);
    chk({nm, "_empty"},   {31'd0, bEmpty},  32'd1);
    chk({nm, "_novalid"}, {31'd0, txValid}, 32'd0);
    txReady = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_hAck"},    {31'd0, hAck},    32'd0);
    chk({nm, "_bWR"},     {31'd0, bWR},     32'd0);
    chk({nm, "_bRD"},     {31'd0, bRD},     32'd0);
    chk({nm, "_bAddr"},   {30'd0, bAddr},   32'd0);
    chk({nm, "_tCount"},  {29'd0, tCount},  32'd0);
    chk({nm, "_bEmpty"},  {31'd0, bEmpty},  32'd1);
    chk({nm, "_hFull"},   {31'd0, hFull},   32'd0);
    chk({nm, "_txValid"}, {31'd0, txValid}, 32'd0);
    chk({nm, "_txData"},  {24'd0, txData},  32'd0);
  endtask

  typedef struct {
    logic         push;
    logic [W-1:0] data;
    logic         ready;
    logic         ack;
    logic         wr;
    logic         rd;
    logic [1:0]   addr;
    logic [2:0]   cnt;
    logic         full;
    logic         valid;
    logic [W-1:0] txd;
  } vec_t;

  vec_t tbl [9];

  // ---------------- main sequence ----------------
  initial begin
    int n_wr, n_rd;
    logic [W-1:0] nxt;

    // push held until accepted; read wins the third cycle, writes resume in CAPT
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'd1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 3'd2, 1'b0, 1'b1, 8'hA5};
    tbl[6] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3, 1'b0, 1'b1, 8'hA5};
    tbl[7] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b1, 8'hA5};
    tbl[8] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b1, 8'hA5};

    // reset state
    repeat (2) @(posedge tClk);
    #1;
    chk_reset_outputs("por");
    tRst = 1'b1;

    // fill to full
    for (int i = 0; i < 9; i++) begin
      hPush = tbl[i].push; hData = tbl[i].data; txReady = tbl[i].ready;
      @(negedge tClk);
      $display("vec %0d data=%02h ack=%0b wr=%0b rd=%0b addr=%0d cnt=%0d valid=%0b",
               i, tbl[i].data, hAck, bWR, bRD, bAddr, tCount, txValid);
      chk("vec_ack",   {31'd0, hAck},   {31'd0, tbl[i].ack});
      chk("vec_wr",    {31'd0, bWR},    {31'd0, tbl[i].wr});
      chk("vec_rd",    {31'd0, bRD},    {31'd0, tbl[i].rd});
      if (tbl[i].wr || tbl[i].rd) chk("vec_addr", {30'd0, bAddr}, {30'd0, tbl[i].addr});
      chk("vec_cnt",   {29'd0, tCount}, {29'd0, tbl[i].cnt});
      chk("vec_full",  {31'd0, hFull},  {31'd0, tbl[i].full});
      chk("vec_valid", {31'd0, txValid}, {31'd0, tbl[i].valid});
      if (tbl[i].valid) chk("vec_txd", {24'd0, txData}, {24'd0, tbl[i].txd});
      @(posedge tClk); #1;
    end
    drain("drain_full");

    // round-robin arbitration with continuous push
    drive_chk("rr_a", 1'b1, 8'hD0, 1'b1, 1'b1, 1'b0);
    drive_chk("rr_b", 1'b1, 8'hD1, 1'b1, 1'b1, 1'b0);
    drive_chk("rr_c", 1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    drive_chk("rr_d", 1'b1, 8'hD2, 1'b1, 1'b0, 1'b1);
    n_wr = 0; n_rd = 0; nxt = 8'hD2;
    for (int i = 0; i < 24; i++) begin
      hPush = 1'b1; hData = nxt; txReady = 1'b1;
      @(negedge tClk);
      if (hAck) nxt = nxt + 8'd1;
      if (bWR) n_wr++;
      if (bRD) n_rd++;
      @(posedge tClk); #1;
    end
    $display("rr window writes=%0d reads=%0d", n_wr, n_rd);
    chk("rr_writes_seen", {31'd0, n_wr >= 3}, 32'd1);
    chk("rr_reads_seen",  {31'd0, n_rd >= 3}, 32'd1);
    drain("drain_rr");

    // hold under back-pressure, writes still accepted
    begin
      int k;
      drive_chk("hold_push", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      hPush = 1'b0; k = 0;
      while (!txValid && k < 10) begin
        @(posedge tClk); #1; k++;
      end
      chk("hold_valid_rise", {31'd0, txValid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        hPush = (i < 3); hData = 8'h40 + 8'(i); txReady = 1'b0;
        @(negedge tClk);
        $display("hold %0d txData=%02h txValid=%0b ack=%0b", i, txData, txValid, hAck);
        chk("hold_txData",  {24'd0, txData},  32'h77);
        chk("hold_txValid", {31'd0, txValid}, 32'd1);
        if (i < 3) chk("hold_ack", {31'd0, hAck}, 32'd1);
        @(posedge tClk); #1;
      end
      drain("drain_hold");
    end

    // reset during CAPT
    tRst = 1'b0;
    @(posedge tClk); #1;
    tRst = 1'b1;
    drive_chk("rst_b1", 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
    drive_chk("rst_b2", 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
    drive_chk("rst_b3", 1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    drive_chk("rst_rd", 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1);
    hPush = 1'b1; hData = 8'hB3;
    @(negedge tClk);
    chk("rst_capt_ack", {31'd0, hAck}, 32'd1);
    #2;
    tRst = 1'b0;
    #1;
    $display("reset asserted mid-transfer hAck=%0b tCount=%0d txValid=%0b", hAck, tCount, txValid);
    chk_reset_outputs("midrst");
    hPush = 1'b0;
    repeat (2) @(posedge tClk);
    #1;
    tRst = 1'b1;
    hPush = 1'b1; hData = 8'h99;
    @(negedge tClk);
    chk("post_rst_ack",  {31'd0, hAck},  32'd1);
    chk("post_rst_addr", {30'd0, bAddr}, 32'd0);
    @(posedge tClk); #1;
    drain("drain_rst");

`ifdef TX_BUF_CTRL_PARITY_EN
    drive_chk("par_07", 1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    drive_chk("par_03", 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    drain("drain_par");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
